// File: rtl/dbus_req_ctrl.sv
// -----------------------------------------------------------------------------
// dbus_req_ctrl
// Data-bus handshake sequencer for the memory stage of the MIPS core.
// Captures one load/store, derives bus address/size/byte strobes (including
// the LWL/LWR/SWL/SWR unaligned forms), drives dreq_valid until the bus
// accepts it, waits for the response and returns the load data. Stalls the
// pipeline while a transaction is open. A flush never cancels an open bus
// transaction; it only suppresses the completion pulse.
//
// Optional build macro: DBUS_TIMEOUT_EN
//   When defined, a response watchdog aborts a transaction that stays open
//   for TIMEOUT_CYCLES cycles and reports it through bus_err. When undefined,
//   bus_err is constant 0 and the FSM waits indefinitely.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_*               memory-stage request (valid, write, msize, kind,
//                       addr, wdata); held until rsp_valid or misalign
//   flush               discard the current request's result
//   dreq_*              bus request (valid, addr, size, strobe, data)
//   dresp_*             bus response (addr_ok, data_ok, data)
//   stall               hold the memory stage
//   rsp_valid/rsp_rdata one-cycle completion pulse and captured read data
//   misalign            combinational address error for normal accesses
//   bus_err             watchdog expiry, qualified by rsp_valid
// -----------------------------------------------------------------------------
module dbus_req_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_msize,
    input  logic [1:0]  req_kind,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [1:0] MSIZE1     = 2'd0;
    localparam logic [1:0] MSIZE2     = 2'd1;
    localparam logic [1:0] MSIZE4     = 2'd2;
    localparam logic [1:0] KIND_LEFT  = 2'd1;
    localparam logic [1:0] KIND_RIGHT = 2'd2;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

    state_t      state_reg, state_next;
    logic        dreq_valid_reg;
    logic [31:0] dreq_addr_reg;
    logic [1:0]  dreq_size_reg;
    logic [3:0]  dreq_strobe_reg;
    logic [31:0] dreq_data_reg;
    logic [31:0] rsp_rdata_reg;
    logic        killed_reg;
    logic        bus_err_reg;

    logic        accept;
    logic        busy;
    logic        timeout_hit;
    logic        unaligned_kind;
    logic [1:0]  off;
    logic [31:0] issue_addr;
    logic [1:0]  issue_size;
    logic [3:0]  issue_strobe;

    assign off            = req_addr[1:0];
    assign unaligned_kind = (req_kind == KIND_LEFT) || (req_kind == KIND_RIGHT);
    assign busy           = (state_reg == REQ) || (state_reg == RESP);
    assign accept         = (state_reg == IDLE) && req_valid && !misalign && !flush;

    // Only normal accesses can fault; LWL/LWR/SWL/SWR are unaligned by design.
    always_comb begin
        misalign = 1'b0;
        if (req_valid && (req_kind == 2'd0)) begin
            if (req_msize == MSIZE2)
                misalign = off[0];
            else if (req_msize == MSIZE4)
                misalign = (off != 2'b00);
        end
    end

    // Unaligned kinds always go out as a word access on the containing word.
    assign issue_addr = unaligned_kind ? {req_addr[31:2], 2'b00} : req_addr;
    assign issue_size = unaligned_kind ? MSIZE4 : req_msize;

    always_comb begin
        issue_strobe = 4'b0000;
        if (req_write) begin
            case (req_kind)
                KIND_LEFT: begin
                    case (off)
                        2'd0:    issue_strobe = 4'b0001;
                        2'd1:    issue_strobe = 4'b0011;
                        2'd2:    issue_strobe = 4'b0111;
                        default: issue_strobe = 4'b1111;
                    endcase
                end
                KIND_RIGHT: begin
                    case (off)
                        2'd0:    issue_strobe = 4'b1111;
                        2'd1:    issue_strobe = 4'b1110;
                        2'd2:    issue_strobe = 4'b1100;
                        default: issue_strobe = 4'b1000;
                    endcase
                end
                default: begin
                    case (req_msize)
                        MSIZE1:  issue_strobe = 4'b0001 << off;
                        MSIZE2:  issue_strobe = off[1] ? 4'b1100 : 4'b0011;
                        MSIZE4:  issue_strobe = 4'b1111;
                        default: issue_strobe = 4'b0000;
                    endcase
                end
            endcase
        end
    end

`ifdef DBUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wd_cnt_reg;

    // Counts cycles spent in REQ/RESP; restarts whenever a request is issued.
    always_ff @(posedge clk) begin
        if (reset)
            wd_cnt_reg <= '0;
        else if (accept)
            wd_cnt_reg <= '0;
        else if (busy)
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end

    // Fires in the TIMEOUT_CYCLES-th open cycle, so DONE follows immediately.
    assign timeout_hit = busy && (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = REQ;
            REQ: begin
                // The watchdog outranks a bare addr_ok so the counter can never
                // run past its limit while still in RESP.
                if (dresp_addr_ok && dresp_data_ok) state_next = DONE;
                else if (timeout_hit)               state_next = DONE;
                else if (dresp_addr_ok)             state_next = RESP;
            end
            RESP: if (dresp_data_ok || timeout_hit) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            dreq_valid_reg  <= 1'b0;
            dreq_addr_reg   <= '0;
            dreq_size_reg   <= '0;
            dreq_strobe_reg <= '0;
            dreq_data_reg   <= '0;
            rsp_rdata_reg   <= '0;
            killed_reg      <= 1'b0;
            bus_err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dreq_valid_reg  <= 1'b1;
                        dreq_addr_reg   <= issue_addr;
                        dreq_size_reg   <= issue_size;
                        dreq_strobe_reg <= issue_strobe;
                        dreq_data_reg   <= req_wdata;
                    end
                end
                REQ: begin
                    if (flush) killed_reg <= 1'b1;
                    if (dresp_addr_ok && dresp_data_ok) begin
                        dreq_valid_reg <= 1'b0;
                        rsp_rdata_reg  <= dresp_data;
                    end else if (timeout_hit) begin
                        dreq_valid_reg <= 1'b0;
                        rsp_rdata_reg  <= '0;
                        bus_err_reg    <= 1'b1;
                    end else if (dresp_addr_ok) begin
                        dreq_valid_reg <= 1'b0;
                    end
                end
                RESP: begin
                    if (flush) killed_reg <= 1'b1;
                    if (dresp_data_ok) begin
                        rsp_rdata_reg <= dresp_data;
                    end else if (timeout_hit) begin
                        rsp_rdata_reg <= '0;
                        bus_err_reg   <= 1'b1;
                    end
                end
                default: begin
                    killed_reg  <= 1'b0;
                    bus_err_reg <= 1'b0;
                end
            endcase
        end
    end

    assign dreq_valid  = dreq_valid_reg;
    assign dreq_addr   = dreq_addr_reg;
    assign dreq_size   = dreq_size_reg;
    assign dreq_strobe = dreq_strobe_reg;
    assign dreq_data   = dreq_data_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign bus_err     = bus_err_reg;
    assign stall       = busy || accept;
    // A flushed transaction still completes on the bus but reports nothing.
    assign rsp_valid   = (state_reg == DONE) && !killed_reg;

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dbus_req_ctrl
// Self-checking bench for dbus_req_ctrl. Each transaction is driven cycle by
// cycle from its request cycle (cycle 0); the bench records what it observes
// and compares it against expectations computed from the access rules.
// -----------------------------------------------------------------------------
module tb_dbus_req_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, flush;
    logic [1:0]  req_msize, req_kind;
    logic [31:0] req_addr, req_wdata;
    logic        dreq_valid;
    logic [31:0] dreq_addr, dreq_data;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic        stall, rsp_valid, misalign, bus_err;
    logic [31:0] rsp_rdata;

    int tests = 0;
    int fails = 0;

    dbus_req_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_msize(req_msize),
        .req_kind(req_kind), .req_addr(req_addr), .req_wdata(req_wdata),
        .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          dv_first, dv_drop, stall_last, rsp_first, rsp_width;
        logic [31:0] addr, data, rdata;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic        stable, berr, mis0;
    } obs_t;

    // ---------------- reference model (access rules) ----------------
    function automatic int nbytes(input logic [1:0] ms);
        return 1 << ms;
    endfunction

    function automatic logic m_misalign(input logic [1:0] ms, input logic [1:0] kd, input logic [31:0] ad);
        return (kd == 2'd0) && ((int'(ad[1:0]) % nbytes(ms)) != 0);
    endfunction

    function automatic logic [3:0] m_strobe(input logic wr, input logic [1:0] ms, input logic [1:0] kd,
                                            input logic [31:0] ad);
        int off, v;
        off = int'(ad[1:0]);
        if (!wr)               v = 0;
        else if (kd == 2'd1)   v = (1 << (off + 1)) - 1;
        else if (kd == 2'd2)   v = ((1 << (4 - off)) - 1) << off;
        else                   v = ((1 << nbytes(ms)) - 1) << off;
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_addr(input logic [1:0] kd, input logic [31:0] ad);
        return (kd != 2'd0) ? (ad & ~32'h3) : ad;
    endfunction

    function automatic logic [1:0] m_size(input logic [1:0] ms, input logic [1:0] kd);
        return (kd != 2'd0) ? 2'd2 : ms;
    endfunction

    // ---------------- driver: runs one transaction, records observations ----------------
    task automatic drive_txn(input logic wr, input logic [1:0] ms, input logic [1:0] kd,
                             input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                             input int aok, input int dok, input int fl, input int win,
                             output obs_t o);
        logic active, prev_dv;
        o.dv_first = -1; o.dv_drop = -1; o.stall_last = -1; o.rsp_first = -1; o.rsp_width = 0;
        o.addr = '0; o.data = '0; o.rdata = '0; o.size = '0; o.strobe = '0;
        o.stable = 1'b1; o.berr = 1'b0; o.mis0 = 1'b0;
        active = 1'b1;
        prev_dv = 1'b0;
        for (int c = 0; c < win; c++) begin
            req_valid = active; req_write = wr; req_msize = ms; req_kind = kd;
            req_addr = ad; req_wdata = wd;
            flush = (c == fl);
            dresp_addr_ok = (c == aok);
            dresp_data_ok = (c == dok);
            dresp_data = (c == dok) ? rd : $urandom;
            #1;
            if (c == 0) o.mis0 = misalign;
            if (dreq_valid) begin
                if (o.dv_first < 0) begin
                    o.dv_first = c; o.addr = dreq_addr; o.data = dreq_data;
                    o.size = dreq_size; o.strobe = dreq_strobe;
                end else if (dreq_addr !== o.addr || dreq_data !== o.data ||
                             dreq_size !== o.size || dreq_strobe !== o.strobe) begin
                    o.stable = 1'b0;
                end
            end
            if (!dreq_valid && prev_dv && o.dv_drop < 0) o.dv_drop = c;
            prev_dv = dreq_valid;
            if (stall) o.stall_last = c;
            if (rsp_valid) begin
                if (o.rsp_first < 0) begin
                    o.rsp_first = c; o.rdata = rsp_rdata; o.berr = bus_err;
                end
                o.rsp_width++;
            end
            if (rsp_valid || c == fl || (c == 0 && misalign)) active = 1'b0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        $display("[TB] txn wr=%0d ms=%0d kind=%0d addr=%08h dv@%0d rsp@%0d rdata=%08h", wr, ms, kd, ad,
                 o.dv_first, o.rsp_first, o.rdata);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; flush = 1'b0; req_write = 1'b0; req_msize = '0; req_kind = '0;
        req_addr = '0; req_wdata = '0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data} !== '0) begin
            fails++; $display("FAIL reset_dreq: got v=%b a=%h s=%0d st=%b d=%h want all 0",
                              dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data);
        end
        tests++;
        if ({rsp_valid, rsp_rdata, bus_err, stall, misalign} !== '0) begin
            fails++; $display("FAIL reset_rsp: got rv=%b rd=%h be=%b st=%b mis=%b want all 0",
                              rsp_valid, rsp_rdata, bus_err, stall, misalign);
        end
    endtask

    task automatic test_sb();
        obs_t o;
        drive_txn(1'b1, 2'd0, 2'd0, 32'h1003, 32'hAA000000, 32'h1234_5678, 1, 1, -1, 4, o);
        tests++; if (o.strobe !== 4'b1000) begin fails++; $display("FAIL sb_strobe: got %b want 1000", o.strobe); end
        tests++; if (o.size !== 2'd0) begin fails++; $display("FAIL sb_size: got %0d want 0", o.size); end
        tests++; if (o.addr !== 32'h1003 || o.data !== 32'hAA000000) begin
            fails++; $display("FAIL sb_addr_data: got %h/%h want 00001003/aa000000", o.addr, o.data); end
        tests++; if (o.rsp_first != 2) begin fails++; $display("FAIL sb_latency: got %0d want 2", o.rsp_first); end
        tests++; if (o.stall_last != 1) begin fails++; $display("FAIL sb_stall: last stall cycle %0d want 1", o.stall_last); end
    endtask

    task automatic test_lw();
        obs_t o;
        drive_txn(1'b0, 2'd2, 2'd0, 32'h2000, 32'h0, 32'hDEADBEEF, 1, 4, -1, 7, o);
        tests++; if (o.rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata: got %h want deadbeef", o.rdata); end
        tests++; if (o.rsp_width != 1 || o.rsp_first != 5) begin
            fails++; $display("FAIL lw_pulse: got width %0d at %0d want 1 at 5", o.rsp_width, o.rsp_first); end
        tests++; if (o.dv_drop != 2) begin fails++; $display("FAIL lw_dv_drop: got %0d want 2", o.dv_drop); end
        tests++; if (o.strobe !== 4'b0000) begin fails++; $display("FAIL lw_strobe: got %b want 0000", o.strobe); end
    endtask

    task automatic test_swl_swr();
        obs_t o;
        drive_txn(1'b1, 2'd0, 2'd2, 32'h3001, 32'h1122_3344, 32'h0, 1, 2, -1, 5, o);
        tests++; if (o.addr !== 32'h3000 || o.strobe !== 4'b1110 || o.size !== 2'd2) begin
            fails++; $display("FAIL swr: got addr %h strobe %b size %0d want 00003000 1110 2", o.addr, o.strobe, o.size); end
        drive_txn(1'b1, 2'd0, 2'd1, 32'h3002, 32'h5566_7788, 32'h0, 2, 2, -1, 5, o);
        tests++; if (o.addr !== 32'h3000 || o.strobe !== 4'b0111 || o.size !== 2'd2) begin
            fails++; $display("FAIL swl: got addr %h strobe %b size %0d want 00003000 0111 2", o.addr, o.strobe, o.size); end
    endtask

    task automatic test_misalign();
        obs_t o;
        drive_txn(1'b0, 2'd1, 2'd0, 32'h4001, 32'h0, 32'h0, 1, 1, -1, 3, o);
        tests++; if (o.mis0 !== 1'b1) begin fails++; $display("FAIL lh_misalign: got %b want 1", o.mis0); end
        tests++; if (o.dv_first != -1 || o.stall_last != -1 || o.rsp_first != -1) begin
            fails++; $display("FAIL lh_quiet: got dv@%0d stall@%0d rsp@%0d want all -1", o.dv_first, o.stall_last, o.rsp_first); end
    endtask

    task automatic test_flush();
        obs_t o;
        drive_txn(1'b1, 2'd2, 2'd0, 32'h5000, 32'hCAFE_F00D, 32'h0BAD_0BAD, 1, 5, 2, 7, o);
        tests++; if (o.rsp_first != -1) begin fails++; $display("FAIL flush_rsp: rsp at %0d want none", o.rsp_first); end
        tests++; if (o.stall_last != 5) begin fails++; $display("FAIL flush_stall: last stall %0d want 5", o.stall_last); end
        tests++; if (o.dv_drop != 2) begin fails++; $display("FAIL flush_dv: drop at %0d want 2", o.dv_drop); end
        // flush in IDLE: request must not issue
        drive_txn(1'b0, 2'd2, 2'd0, 32'h5100, 32'h0, 32'h0, 1, 1, 0, 3, o);
        tests++; if (o.dv_first != -1 || o.stall_last != -1) begin
            fails++; $display("FAIL flush_idle: dv@%0d stall@%0d want none", o.dv_first, o.stall_last); end
        // the next request issues normally
        drive_txn(1'b0, 2'd2, 2'd0, 32'h5200, 32'h0, 32'h600D_600D, 1, 2, -1, 5, o);
        tests++; if (o.rsp_first != 3 || o.rdata !== 32'h600D_600D) begin
            fails++; $display("FAIL flush_next: rsp@%0d rdata %h want 3 600d600d", o.rsp_first, o.rdata); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        // window ends on the DONE cycle, so the next request lands in the first IDLE cycle
        drive_txn(1'b0, 2'd2, 2'd0, 32'h6000, 32'h0, 32'hA5A5_0001, 1, 1, -1, 3, o);
        tests++; if (o.rsp_first != 2) begin fails++; $display("FAIL b2b_first: rsp@%0d want 2", o.rsp_first); end
        drive_txn(1'b1, 2'd2, 2'd0, 32'h6004, 32'h1357_9BDF, 32'hA5A5_0002, 1, 1, -1, 4, o);
        tests++; if (o.dv_first != 1 || o.rsp_first != 2 || o.rsp_width != 1) begin
            fails++; $display("FAIL b2b_second: dv@%0d rsp@%0d width %0d want 1 2 1", o.dv_first, o.rsp_first, o.rsp_width); end
        tests++; if (o.data !== 32'h1357_9BDF || o.strobe !== 4'b1111) begin
            fails++; $display("FAIL b2b_data: got %h %b want 13579bdf 1111", o.data, o.strobe); end
    endtask

    task automatic test_random();
        obs_t o;
        logic wr; logic [1:0] ms, kd; logic [31:0] ad, wd, rd;
        int aok, dok, fl, win;
        logic mis;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom); kd = 2'($urandom_range(0, 2)); ms = 2'($urandom_range(0, 2));
            ad = $urandom; wd = $urandom; rd = $urandom;
            if (kd == 2'd0 && ($urandom_range(0, 2) != 0)) ad[1:0] = ad[1:0] & 2'(~(nbytes(ms) - 1));
            aok = $urandom_range(1, 3);
            dok = aok + int'($urandom_range(0, 3));
            fl  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, dok)) : -1;
            mis = m_misalign(ms, kd, ad);
            win = mis ? 3 : dok + 3;
            drive_txn(wr, ms, kd, ad, wd, rd, aok, dok, fl, win, o);
            tests++; if (o.mis0 !== mis) begin fails++; $display("FAIL rnd%0d_misalign: got %b want %b", i, o.mis0, mis); end
            if (mis) begin
                tests++; if (o.dv_first != -1 || o.stall_last != -1 || o.rsp_first != -1) begin
                    fails++; $display("FAIL rnd%0d_quiet: dv@%0d stall@%0d rsp@%0d want none", i, o.dv_first, o.stall_last, o.rsp_first); end
            end else begin
                tests++; if (o.addr !== m_addr(kd, ad) || o.size !== m_size(ms, kd)) begin
                    fails++; $display("FAIL rnd%0d_addr: got %h/%0d want %h/%0d", i, o.addr, o.size, m_addr(kd, ad), m_size(ms, kd)); end
                tests++; if (o.strobe !== m_strobe(wr, ms, kd, ad) || o.data !== wd) begin
                    fails++; $display("FAIL rnd%0d_strobe: got %b/%h want %b/%h", i, o.strobe, o.data, m_strobe(wr, ms, kd, ad), wd); end
                tests++; if (o.dv_first != 1 || o.dv_drop != aok + 1 || !o.stable) begin
                    fails++; $display("FAIL rnd%0d_dv: got %0d..%0d stable %b want 1..%0d stable 1", i, o.dv_first, o.dv_drop, o.stable, aok + 1); end
                tests++; if (o.stall_last != dok) begin
                    fails++; $display("FAIL rnd%0d_stall: last %0d want %0d", i, o.stall_last, dok); end
                if (fl >= 0) begin
                    tests++; if (o.rsp_first != -1) begin fails++; $display("FAIL rnd%0d_flushed: rsp@%0d want none", i, o.rsp_first); end
                end else begin
                    tests++; if (o.rsp_first != dok + 1 || o.rsp_width != 1 || o.rdata !== rd || o.berr !== 1'b0) begin
                        fails++; $display("FAIL rnd%0d_rsp: got @%0d w%0d %h be%b want @%0d w1 %h be0", i, o.rsp_first, o.rsp_width, o.rdata, o.berr, dok + 1, rd); end
                end
            end
        end
    endtask

    task automatic test_watchdog();
        obs_t o;
`ifdef DBUS_TIMEOUT_EN
        drive_txn(1'b0, 2'd2, 2'd0, 32'h7000, 32'h0, 32'h0, -1, -1, -1, 12, o);
        tests++; if (o.rsp_first != 9 || o.berr !== 1'b1 || o.rdata !== 32'h0) begin
            fails++; $display("FAIL timeout_rsp: got @%0d be%b rd %h want @9 be1 0", o.rsp_first, o.berr, o.rdata); end
        tests++; if (o.dv_drop != 9 || o.stall_last != 8) begin
            fails++; $display("FAIL timeout_dv: drop %0d stall %0d want 9 8", o.dv_drop, o.stall_last); end
`else
        drive_txn(1'b0, 2'd2, 2'd0, 32'h7000, 32'h0, 32'h0, -1, -1, -1, 20, o);
        tests++; if (o.rsp_first != -1 || o.stall_last != 19 || o.dv_drop != -1) begin
            fails++; $display("FAIL wait_forever: rsp@%0d stall %0d drop %0d want none 19 none", o.rsp_first, o.stall_last, o.dv_drop); end
`endif
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b1; req_msize = 2'd2; req_kind = 2'd0;
        req_addr = 32'h8000; req_wdata = 32'hFFFF_FFFF;
        repeat (4) begin @(posedge clk); #1; end
        tests++; if (dreq_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre: dreq_valid %b want 1", dreq_valid); end
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, rsp_valid, rsp_rdata, bus_err, stall} !== '0) begin
            fails++; $display("FAIL rstmid_outputs: v=%b a=%h s=%0d st=%b d=%h rv=%b rd=%h be=%b stall=%b want all 0",
                              dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, rsp_valid, rsp_rdata, bus_err, stall);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sb();
        test_lw();
        test_swl_swr();
        test_misalign();
        test_flush();
        test_back_to_back();
        test_random();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dbus_req_ctrl.md
Name: dbus_req_ctrl

Overview:
- Sequences the data-bus handshake for the memory stage of the MIPS core.
- Captures one load/store request and derives byte strobes from size, offset and LWL/LWR/SWL/SWR kind.
- Drives dreq until accepted, then waits for the response and returns load data.
- Stalls the pipeline while busy, and absorbs flushes without breaking an in-flight bus transaction.

Parameters:
- TIMEOUT_CYCLES, 255: response watchdog limit; only used with DBUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  memory-stage access present; held until rsp_valid or misalign
- req_write  in  1  1 = store, 0 = load
- req_msize  in  2  MSIZE1=0, MSIZE2=1, MSIZE4=2
- req_kind  in  2  0 normal, 1 LWL/SWL, 2 LWR/SWR
- req_addr  in  32  byte address
- req_wdata  in  32  store data, already lane-aligned upstream
- flush  in  1  pipeline flush; discard current request result
- dreq_valid  out  1  bus request valid
- dreq_addr  out  32  bus address
- dreq_size  out  2  bus size
- dreq_strobe  out  4  byte write enables (0000 on loads)
- dreq_data  out  32  bus write data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  response complete
- dresp_data  in  32  read data
- stall  out  1  hold memory stage
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data captured at data_ok
- misalign  out  1  combinational; normal access misaligned (AdEL/AdES)
- bus_err  out  1  watchdog expiry, valid with rsp_valid

Behaviour:
- Reset values: state IDLE; all dreq_* 0; rsp_valid 0; rsp_rdata 0; bus_err 0. misalign is combinational.
- States: IDLE, REQ, RESP, DONE.

Misalign:
- misalign = req_valid & kind==0 & ((MSIZE2 & addr[0]) | (MSIZE4 & addr[1:0]!=0)).
- On misalign the FSM stays in IDLE, issues no bus request, and holds stall and rsp_valid at 0.

IDLE:
- On req_valid & ~misalign & ~flush: latch address, size, strobe and data into the dreq_* registers, set dreq_valid=1, go to REQ.
- stall=1 in that same cycle.

Address and size:
- kind 0: dreq_addr = req_addr; dreq_size = msize.
- kind 1 or 2: dreq_addr = {req_addr[31:2],2'b00}; dreq_size = MSIZE4.

Strobe:
- Loads: 0000.
- MSIZE1: 0001<<off.
- MSIZE2: off0 → 0011, off2 → 1100.
- MSIZE4 normal: 1111.
- SWL: off0..3 → 0001, 0011, 0111, 1111.
- SWR: off0..3 → 1111, 1110, 1100, 1000.

REQ:
- dreq_* held stable until dresp_addr_ok.
- addr_ok & data_ok in the same cycle: capture data, go to DONE.
- addr_ok alone: go to RESP.
- dreq_valid drops in the cycle after addr_ok is seen.

RESP:
- On data_ok: capture dresp_data into rsp_rdata, go to DONE.

DONE:
- rsp_valid=1 for one cycle, unless the transaction was flushed.
- Return to IDLE.
- A new request is accepted from the next cycle, so back-to-back issue spacing is 1 idle cycle minimum.

Stall:
- stall = (state ∈ {REQ,RESP}) | (IDLE & req_valid & ~misalign & ~flush).
- stall = 0 in DONE.

Flush:
- Flush in REQ or RESP sets a sticky `killed` bit.
- The transaction still runs to data_ok; dreq_valid is never retracted before addr_ok.
- In DONE with killed set: rsp_valid is suppressed and killed is cleared.
- Flush in IDLE: no request is issued.

Reset:
- Reset mid-transaction returns the FSM to IDLE immediately and drops dreq_valid.
- The bus is reset by the same signal.

Latency:
- Best case: accept in cycle 0, dreq_valid in cycle 1, addr_ok & data_ok in cycle 1, rsp_valid in cycle 2.

Optional Feature:
- Macro DBUS_TIMEOUT_EN.
- When defined: an 8+ bit counter clears on entering REQ and increments each cycle in REQ or RESP. When it reaches TIMEOUT_CYCLES, go to DONE with bus_err=1, rsp_rdata=0, and dreq_valid dropped.
- When undefined: no counter; bus_err is tied to 0; the FSM waits indefinitely.

Test Plan:
- SB: addr 0x1003, data 0xAA000000, addr_ok+data_ok in the first REQ cycle → dreq_strobe=1000, dreq_size=0, rsp_valid in cycle 2, stall high for cycles 0–1.
- LW: addr 0x2000, addr_ok at cycle 1, data_ok with 0xDEADBEEF at cycle 4 → rsp_rdata=0xDEADBEEF, rsp_valid pulse of exactly 1 cycle, dreq_valid low from cycle 2.
- SWR at 0x3001 → dreq_addr=0x3000, strobe=1110. SWL at 0x3002 → strobe=0111.
- LH at 0x4001 → misalign=1, dreq_valid stays 0, stall=0, rsp_valid=0.
- SW with flush asserted while in RESP, data_ok 3 cycles later → no rsp_valid, stall held until DONE, next request issues normally.
- DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, addr_ok never asserted → after 8 cycles bus_err=1 with rsp_valid, FSM returns to IDLE. Also assert reset mid-REQ → all outputs return to 0 the next cycle.
